// File: rtl/led_alarm_pkg.sv
// Shared enumerations and default timing constants for the LED alarm pattern block.
package led_alarm_pkg;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_ZONE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_ON  = 2'd1,
    ST_RUN_OFF = 2'd2
  } state_e;

  localparam int DEF_CLK_HZ   = 50_000_000;
  localparam int DEF_BLINK_HZ = 1;

endpackage

// File: rtl/led_alarm_pattern_tick_gen.sv
// Phase prescaler: counts 0..HALF-1 while enabled; tick is high in the cycle whose edge wraps it.
module tick_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_alarm_pattern.sv
// Alarm LED pattern generator: steady, blink, chase and per-zone sticky blink, all outputs registered.
module led_alarm_pattern
  import led_alarm_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int BLINK_HZ = DEF_BLINK_HZ,
  parameter int N_LEDS   = 12,
  parameter int N_ZONES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic [1:0]         mode,
  input  logic [N_ZONES-1:0] zone,
  output logic [N_LEDS-1:0]  ledr,
  output logic               tick
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int GRP  = N_LEDS / N_ZONES;
  localparam int PW   = $clog2(N_LEDS);
  localparam logic [PW-1:0] PLAST = PW'(N_LEDS - 1);

  state_e             state;
  mode_e              mode_q;
  mode_e              mode_in;
  logic [PW-1:0]      pos;
  logic [N_ZONES-1:0] latch;
  logic               run;
  logic               mode_chg;
  logic               clr;
  logic               en;
  logic               wrap;

  assign mode_in  = mode_e'(mode);
  assign run      = (state != ST_IDLE);
  assign mode_chg = run && arm && (mode_in != mode_q);
  assign en       = run && arm;
  assign clr      = !arm || !run || mode_chg;

  tick_gen #(.HALF(HALF)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .tick (wrap)
  );

  // Output pattern from the current registered state; registering it gives the one-clock latency.
  function automatic logic [N_LEDS-1:0] pattern(state_e st, mode_e md,
                                               logic [PW-1:0] p, logic [N_ZONES-1:0] lt);
    logic              on;
    logic [N_LEDS-1:0] v;
    on = (st != ST_RUN_OFF);
    v  = '1;
    case (md)
      MODE_BLINK: v = {N_LEDS{on}};
      MODE_CHASE: if (st != ST_IDLE) v = N_LEDS'(1) << p;
      MODE_ZONE: begin
        for (int i = 0; i < N_LEDS; i++) begin
          if (lt[i / GRP]) v[i] = on;
        end
      end
      default: v = '1;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_STEADY;
      pos    <= '0;
      latch  <= '0;
      ledr   <= '0;
      tick   <= 1'b0;
    end else begin
      mode_q <= mode_in;
      ledr   <= pattern(state, mode_q, pos, latch);
      tick   <= wrap;
      if (!arm) begin
        state <= ST_IDLE;
        pos   <= '0;
        latch <= '0;
      end else begin
        latch <= latch | zone;
        if (!run || mode_chg) begin
          state <= ST_RUN_ON;
          pos   <= '0;
        end else if (wrap) begin
          state <= (state == ST_RUN_ON) ? ST_RUN_OFF : ST_RUN_ON;
          pos   <= (pos == PLAST) ? '0 : pos + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_alarm_pattern.sv
// Directed bench for led_alarm_pattern with HALF=4, four LEDs in two zones.
module tb_led_alarm_pattern;

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic [1:0] mode;
  logic [1:0] zone;
  logic [3:0] ledr;
  logic       tick;

  int checks;
  int failures;

  led_alarm_pattern #(
    .CLK_HZ  (8),
    .BLINK_HZ(1),
    .N_LEDS  (4),
    .N_ZONES (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .arm  (arm),
    .mode (mode),
    .zone (zone),
    .ledr (ledr),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Blink cycles n=1..ncyc after arming: on for 1-4, off for 5-8, ...; tick every 4th cycle.
  task automatic run_blink(input string tag, input int ncyc);
    logic [3:0] el;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      el = (((n - 1) / 4) % 2 == 1) ? 4'b0000 : 4'b1111;
      chk($sformatf("%s_led_c%0d", tag, n), 32'(ledr), 32'(el));
      chk($sformatf("%s_tick_c%0d", tag, n), 32'(tick), 32'((n % 4) == 0));
    end
  endtask

  task automatic disarm_to_idle(input string tag);
    arm = 1'b0;
    step();
    step();
    chk({tag, "_idle_led"}, 32'(ledr), 32'hF);
    chk({tag, "_idle_tick"}, 32'(tick), 32'h0);
  endtask

  initial begin
    logic [3:0] el;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    arm = 1'b0;
    mode = 2'd0;
    zone = 2'b00;

    // Reset with arm low, then release
    step();
    chk("rst_led", 32'(ledr), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rel_led", 32'(ledr), 32'hF);
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("idle_tick_%0d", n), 32'(tick), 32'h0);
    end
    chk("idle_led", 32'(ledr), 32'hF);

    // BLINK
    mode = 2'd1;
    step();
    arm = 1'b1;
    step();
    chk("blink_c0_led", 32'(ledr), 32'hF);
    run_blink("blink", 16);
    disarm_to_idle("blink");

    // CHASE: one lit LED advancing each tick, wrapping after bit 3
    mode = 2'd2;
    step();
    arm = 1'b1;
    step();
    for (int n = 1; n <= 20; n++) begin
      step();
      el = 4'b0001 << (((n - 1) / 4) % 4);
      chk($sformatf("chase_led_c%0d", n), 32'(ledr), 32'(el));
      chk($sformatf("chase_tick_c%0d", n), 32'(tick), 32'((n % 4) == 0));
    end
    disarm_to_idle("chase");

    // ZONE: zone 0 pulsed for one cycle at cycle 2 stays latched
    mode = 2'd3;
    step();
    arm = 1'b1;
    step();
    for (int n = 1; n <= 16; n++) begin
      zone = (n == 2) ? 2'b01 : 2'b00;
      step();
      el = (((n - 1) / 4) % 2 == 1) ? 4'b1100 : 4'b1111;
      chk($sformatf("zone_led_c%0d", n), 32'(ledr), 32'(el));
    end
    zone = 2'b00;
    disarm_to_idle("zone");
    arm = 1'b1;
    step();
    for (int n = 1; n <= 8; n++) begin
      step();
      chk($sformatf("zone_clr_led_c%0d", n), 32'(ledr), 32'hF);
    end
    arm = 1'b0;
    step();
    step();

    // BLINK -> CHASE switch at cycle 6, during the off phase
    mode = 2'd1;
    step();
    arm = 1'b1;
    step();
    run_blink("sw_pre", 5);
    mode = 2'd2;
    step();
    chk("sw_c6_led", 32'(ledr), 32'h0);
    chk("sw_c6_tick", 32'(tick), 32'h0);
    step();
    chk("sw_c7_led", 32'(ledr), 32'h1);
    step();
    chk("sw_c8_tick", 32'(tick), 32'h0);
    step();
    chk("sw_c9_tick", 32'(tick), 32'h0);
    step();
    chk("sw_c10_tick", 32'(tick), 32'h1);
    chk("sw_c10_led", 32'(ledr), 32'h1);
    step();
    chk("sw_c11_led", 32'(ledr), 32'h2);
    chk("sw_c11_tick", 32'(tick), 32'h0);
    disarm_to_idle("sw");

    // Reset pulsed mid-BLINK at cycle 7
    mode = 2'd1;
    step();
    arm = 1'b1;
    step();
    run_blink("rp_pre", 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rp_async_led", 32'(ledr), 32'h0);
    chk("rp_async_tick", 32'(tick), 32'h0);
    step();
    chk("rp_hold_led", 32'(ledr), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rp_rel_led", 32'(ledr), 32'hF);
    chk("rp_rel_tick", 32'(tick), 32'h0);
    run_blink("rp_post", 8);
    disarm_to_idle("rp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_alarm_pattern.md
LED_ALARM_PATTERN -- requirements
Module: led_alarm_pattern

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 Parameter BLINK_HZ, default 1: full on+off blink rate in Hz; HALF = CLK_HZ/(2*BLINK_HZ) clocks per phase.
REQ-003 Parameter N_LEDS, default 12: LED output width, at least 2.
REQ-004 Parameter N_ZONES, default 4: zone input count; N_LEDS SHALL be a multiple of N_ZONES; GRP = N_LEDS/N_ZONES.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 arm  input  1  alarm active; 1 = pattern running, 0 = idle.
REQ-008 mode  input  2  pattern select: 0 STEADY, 1 BLINK, 2 CHASE, 3 ZONE.
REQ-009 zone  input  N_ZONES  per-zone trigger flags, level-sensitive.
REQ-010 ledr  output  N_LEDS  registered LED drive, 1 = lit.
REQ-011 tick  output  1  one-cycle pulse at every phase boundary while armed.

Function
REQ-012 States: IDLE, RUN_ON, RUN_OFF; transitions only on the rising edge of clk.
REQ-013 IDLE: ledr = all ones, prescaler = 0, chase position = 0, tick = 0.
REQ-014 IDLE -> RUN_ON on the first edge where arm = 1; the prescaler starts at 0 on that edge.
REQ-015 Prescaler counts 0..HALF-1; on the edge where it equals HALF-1 it wraps to 0, tick pulses for exactly that cycle, and the state toggles RUN_ON <-> RUN_OFF.
REQ-016 Any state -> IDLE on the first edge where arm = 0; no partial phase is completed.
REQ-017 A mode change while armed SHALL clear the prescaler, force RUN_ON, and reset the chase position to 0 on the same edge.
REQ-018 STEADY: ledr = all ones in both RUN states.
REQ-019 BLINK: ledr = all ones in RUN_ON and all zeros in RUN_OFF.
REQ-020 CHASE: exactly one LED is lit, at bit index pos; pos increments on every tick and wraps from N_LEDS-1 to 0; RUN_ON and RUN_OFF do not blank the output.
REQ-021 ZONE: zone flags are latched sticky (latch |= zone) while armed and cleared in IDLE.
REQ-022 ZONE output: LED group k (bits k*GRP..k*GRP+GRP-1) blinks per REQ-019 if latch[k] = 1; otherwise it is steady on.
REQ-023 ZONE timing: a zone asserted mid-phase takes effect at the next edge and does not restart the prescaler.
REQ-024 Latency: ledr reflects state, mode and latch one clock after they change; there is no combinational path from inputs to ledr.
REQ-025 Width rule: the prescaler width is clog2(HALF) and the chase position width is clog2(N_LEDS); neither counter may exceed its terminal value.

Reset
REQ-026 rst_n = 0 asynchronously forces state IDLE, prescaler 0, pos 0, latch 0, ledr all zeros, and tick 0.
REQ-027 After rst_n deasserts, the first edge loads ledr = all ones (IDLE), or enters RUN_ON if arm = 1.
REQ-028 Reset asserted mid-pattern aborts immediately, with no glitch beyond the asynchronous clear.

Structure
REQ-029 Package led_alarm_pkg SHALL hold the mode and state enumerations and the default CLK_HZ and BLINK_HZ constants.
REQ-030 Sub-module tick_gen (parameter HALF, inputs clk, rst_n, clr, en; output tick) SHALL implement the prescaler.

Verification (CLK_HZ=8, BLINK_HZ=1, so HALF=4; N_LEDS=4; N_ZONES=2)
REQ-031 Reset with arm=0, then release -> ledr 0000 during reset, 1111 on the first edge after release, and tick never pulses.
REQ-032 BLINK with arm rising at cycle 0 -> ledr 1111 for cycles 1-4, 0000 for cycles 5-8, then 1111 again; tick pulses at cycles 4, 8 and 12.
REQ-033 CHASE, armed for 20 cycles -> ledr sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles.
REQ-034 ZONE with zone=01 pulsed for 1 cycle at cycle 2 -> bits[1:0] blink and bits[3:2] stay 11; the latch persists until arm=0, after which ledr = 1111.
REQ-035 Mode switched from BLINK to CHASE at cycle 6, during RUN_OFF -> ledr 0001 next cycle, and the next tick follows exactly 4 cycles later.
REQ-036 rst_n pulsed low at cycle 7 in BLINK -> ledr 0000 immediately; after release it resumes RUN_ON with a fresh 4-cycle phase.
